// File: rtl/cam_frame_capture.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | cam_frame_capture: decimating DVP camera frame grabber to pixel RAM    |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module cam_frame_capture #(
   parameter int IMG_W  = 320,
   parameter int IMG_H  = 240,
   parameter int DEC_X  = 2,
   parameter int DEC_Y  = 2,
   parameter int ADDR_W = 17
) (
   input  logic              pclk,
   input  logic              rst_n,
   input  logic              vsync,
   input  logic              href,
   input  logic [7:0]        d,
   input  logic              cap_en,
   input  logic              snapshot,
   input  logic [1:0]        mode,
   output logic [ADDR_W-1:0] addr,
   output logic [15:0]       dout,
   output logic              we,
   output logic              frame_done,
   output logic              busy,
   output logic [15:0]       frame_cnt,
   output logic              line_err
);

   localparam logic [ADDR_W-1:0] c_TOTAL      = ADDR_W'(IMG_W * IMG_H);
   localparam logic [15:0]       c_LINE_BYTES = 16'(2 * IMG_W * DEC_X);
   localparam logic [15:0]       c_W16        = 16'(IMG_W);
   localparam logic [15:0]       c_H16        = 16'(IMG_H);
   localparam logic [1:0]        c_DX_LAST    = 2'(DEC_X - 1);
   localparam logic [1:0]        c_DY_LAST    = 2'(DEC_Y - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARM    = 2'd1,
      S_VBLANK = 2'd2,
      S_ACTIVE = 2'd3
   } state_t;

   state_t            r_state, w_state_nxt;
   logic              r_vs, r_hr, r_vs_d, r_hr_d;
   logic [7:0]        r_d, r_b0;
   logic              r_snap_pend, r_phase;
   logic [1:0]        r_mode, r_col_ph, r_line_ph;
   logic [15:0]       r_col_idx, r_line_idx, r_byte_cnt, r_frame_cnt, r_dout;
   logic [ADDR_W-1:0] r_addr;
   logic              r_we, r_frame_done, r_line_err;
   logic              w_act_start, w_frame_end;
   logic [15:0]       w_pix, w_dout;

   wire w_vs_rise  = r_vs & ~r_vs_d;
   wire w_vs_fall  = ~r_vs & r_vs_d;
   wire w_hr_rise  = r_hr & ~r_hr_d;
   wire w_hr_fall  = ~r_hr & r_hr_d;
   wire w_in_frame = (r_state == S_ACTIVE) && !w_vs_rise;
   wire w_phase0   = w_hr_rise | ~r_phase;
   wire w_line_kpt = (r_line_ph == 2'd0) && (r_line_idx < c_H16);
   wire w_col_kpt  = (r_col_ph == 2'd0) && (r_col_idx < c_W16);
   wire w_keep     = w_in_frame && r_hr && !w_phase0 && w_line_kpt && w_col_kpt
                     && (r_addr != c_TOTAL);

   always_comb begin
      w_state_nxt = r_state;
      w_act_start = 1'b0;
      w_frame_end = 1'b0;
      case (r_state)
         S_IDLE:   if (cap_en || snapshot) w_state_nxt = S_ARM;
         S_ARM:    if (w_vs_rise) w_state_nxt = S_VBLANK;
         S_VBLANK: if (w_vs_fall) begin
            w_state_nxt = S_ACTIVE;
            w_act_start = 1'b1;
         end
         S_ACTIVE: if (w_vs_rise) begin
            w_frame_end = 1'b1;
            w_state_nxt = (cap_en || r_snap_pend) ? S_VBLANK : S_IDLE;
         end
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      w_pix = {r_b0, r_d};
      case (r_mode)
         2'b00:   w_dout = {4'h0, w_pix[15:12], w_pix[10:7], w_pix[4:1]};
         2'b10:   w_dout = {8'h00, r_b0};
         default: w_dout = w_pix;
      endcase
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_vs        <= 1'b0;
         r_hr        <= 1'b0;
         r_d         <= 8'h00;
         r_vs_d      <= 1'b0;
         r_hr_d      <= 1'b0;
         r_snap_pend <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_vs    <= vsync;
         r_hr    <= href;
         r_d     <= d;
         r_vs_d  <= r_vs;
         r_hr_d  <= r_hr;
         // A snapshot seen while already capturing buys exactly one more frame
         if (w_frame_end)
            r_snap_pend <= 1'b0;
         if (snapshot && r_state != S_IDLE)
            r_snap_pend <= 1'b1;
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         r_mode       <= 2'b00;
         r_b0         <= 8'h00;
         r_phase      <= 1'b0;
         r_col_ph     <= 2'd0;
         r_col_idx    <= 16'd0;
         r_line_ph    <= 2'd0;
         r_line_idx   <= 16'd0;
         r_byte_cnt   <= 16'd0;
         r_addr       <= '0;
         r_dout       <= 16'h0000;
         r_we         <= 1'b0;
         r_frame_done <= 1'b0;
         r_frame_cnt  <= 16'd0;
         r_line_err   <= 1'b0;
      end else begin
         r_we         <= 1'b0;
         r_frame_done <= 1'b0;
         if (w_act_start) begin
            r_mode     <= (mode == 2'b11) ? 2'b01 : mode;
            r_addr     <= '0;
            r_phase    <= 1'b0;
            r_col_ph   <= 2'd0;
            r_col_idx  <= 16'd0;
            r_line_ph  <= 2'd0;
            r_line_idx <= 16'd0;
            r_byte_cnt <= 16'd0;
            r_line_err <= 1'b0;
         end else begin
            if (r_we && r_addr != c_TOTAL)
               r_addr <= r_addr + ADDR_W'(1);
            if (w_in_frame && r_hr) begin
               r_byte_cnt <= w_hr_rise ? 16'd1 : r_byte_cnt + 16'd1;
               if (w_phase0) begin
                  r_b0    <= r_d;
                  r_phase <= 1'b1;
                  if (w_hr_rise) begin
                     r_col_ph  <= 2'd0;
                     r_col_idx <= 16'd0;
                  end
               end else begin
                  r_phase <= 1'b0;
                  if (r_col_ph == c_DX_LAST) begin
                     r_col_ph <= 2'd0;
                     if (r_col_idx != c_W16)
                        r_col_idx <= r_col_idx + 16'd1;
                  end else begin
                     r_col_ph <= r_col_ph + 2'd1;
                  end
               end
            end
            if (w_in_frame && w_hr_fall) begin
               if (w_line_kpt && r_byte_cnt != c_LINE_BYTES)
                  r_line_err <= 1'b1;
               if (r_line_ph == c_DY_LAST) begin
                  r_line_ph <= 2'd0;
                  if (r_line_idx != c_H16)
                     r_line_idx <= r_line_idx + 16'd1;
               end else begin
                  r_line_ph <= r_line_ph + 2'd1;
               end
            end
         end
         if (w_keep) begin
            r_we   <= 1'b1;
            r_dout <= w_dout;
         end
         if (w_frame_end) begin
            r_frame_done <= 1'b1;
            r_frame_cnt  <= r_frame_cnt + 16'd1;
         end
      end
   end

   assign addr       = r_addr;
   assign dout       = r_dout;
   assign we         = r_we;
   assign frame_done = r_frame_done;
   assign busy       = (r_state != S_IDLE);
   assign frame_cnt  = r_frame_cnt;
   assign line_err   = r_line_err;

endmodule
`default_nettype wire
